// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store unit: FSM states, decoder load/store
// type codes, datapath width and the store-lane / alignment helpers.
package lsu_ctrl_pkg;

  localparam int LSU_XLEN = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LT_NONE = 3'b000;
  localparam logic [2:0] LT_LB   = 3'b001;
  localparam logic [2:0] LT_LBU  = 3'b101;
  localparam logic [2:0] LT_LH   = 3'b010;
  localparam logic [2:0] LT_LHU  = 3'b110;
  localparam logic [2:0] LT_LW   = 3'b011;
  localparam logic [2:0] LT_LWU  = 3'b111;
  localparam logic [2:0] LT_LD   = 3'b100;

  localparam logic [2:0] ST_NONE = 3'b000;
  localparam logic [2:0] ST_SB   = 3'b100;
  localparam logic [2:0] ST_SH   = 3'b101;
  localparam logic [2:0] ST_SW   = 3'b110;
  localparam logic [2:0] ST_SD   = 3'b111;

  // Lanes that fall off the top of the 8-byte word are simply lost.
  function automatic logic [7:0] store_mask(input logic [2:0] st, input logic [2:0] off);
    logic [7:0] m;
    case (st)
      ST_SB:   m = 8'h01 << off;
      ST_SH:   m = 8'h03 << off;
      ST_SW:   m = 8'h0F << off;
      ST_SD:   m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  // log2 of the access size in bytes
  function automatic logic [1:0] access_size(input logic is_store, input logic [2:0] lt,
                                             input logic [2:0] st);
    logic [1:0] sz;
    if (is_store) begin
      sz = st[1:0];
    end else begin
      case (lt)
        LT_LB, LT_LBU: sz = 2'd0;
        LT_LH, LT_LHU: sz = 2'd1;
        LT_LW, LT_LWU: sz = 2'd2;
        default:       sz = 2'd3;
      endcase
    end
    return sz;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    logic m;
    case (sz)
      2'd0:    m = 1'b0;
      2'd1:    m = off[0];
      2'd2:    m = |off[1:0];
      default: m = |off;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_ext.sv
// Load result alignment: shifts the 8-byte-aligned response down to the
// addressed byte and sign/zero-extends according to the load type.
module lsu_ext
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
) (
  input  logic [2:0]      i_load_type,
  input  logic [2:0]      i_off,
  input  logic [XLEN-1:0] i_rsp_data,
  output logic [XLEN-1:0] o_ext_data
);

  logic [XLEN-1:0] w_shifted;

  // Byte-lane shift followed by width selection and extension.
  always_comb begin
    w_shifted  = i_rsp_data >> {i_off, 3'b000};
    o_ext_data = {XLEN{1'b0}};
    case (i_load_type)
      LT_LB:   o_ext_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      LT_LBU:  o_ext_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      LT_LH:   o_ext_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      LT_LHU:  o_ext_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      LT_LW:   o_ext_data = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      LT_LWU:  o_ext_data = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
      LT_LD:   o_ext_data = w_shifted;
      default: o_ext_data = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: latches one memory-stage access, runs the
// dmem request/response handshake and returns the extended load result.
// Optional alignment trap: define LSU_MISALIGN_CHECK_EN.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      load_type,
  input  logic [2:0]      store_type,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            lsu_stall,
  output logic            lsu_done,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic            dmem_req_wen,
  output logic [7:0]      dmem_req_wmask,
  output logic [XLEN-1:0] dmem_req_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rsp_data
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic            lsu_misalign
`endif
);

  lsu_state_e      r_state;
  lsu_state_e      w_next_state;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [2:0]      r_load_type;
  logic [2:0]      r_store_type;
  logic            r_is_store;
  logic [XLEN-1:0] r_rdata;
  logic [XLEN-1:0] w_ext;
  logic            w_start;

  assign w_start = ex_valid & (mem_read | mem_write);

`ifdef LSU_MISALIGN_CHECK_EN
  logic w_misalign;
  logic r_misalign;

  assign w_misalign = misaligned(access_size(mem_write, load_type, store_type), addr[2:0]);
`endif

  lsu_ext #(.XLEN(XLEN)) u_ext (
    .i_load_type (r_load_type),
    .i_off       (r_addr[2:0]),
    .i_rsp_data  (dmem_rsp_data),
    .o_ext_data  (w_ext)
  );

  // Next-state logic for the access sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
`ifdef LSU_MISALIGN_CHECK_EN
          if (w_misalign) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_REQ;
          end
`else
          w_next_state = S_REQ;
`endif
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_REQ: begin
        if (dmem_req_ready) begin
          w_next_state = S_WAIT;
        end else begin
          w_next_state = S_REQ;
        end
      end
      S_WAIT: begin
        if (dmem_rsp_valid) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register, access latches and load result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= {XLEN{1'b0}};
      r_wdata      <= {XLEN{1'b0}};
      r_load_type  <= LT_NONE;
      r_store_type <= ST_NONE;
      r_is_store   <= 1'b0;
      r_rdata      <= {XLEN{1'b0}};
`ifdef LSU_MISALIGN_CHECK_EN
      r_misalign   <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && w_start) begin
        r_addr       <= addr;
        r_wdata      <= wdata;
        r_load_type  <= load_type;
        r_store_type <= store_type;
        r_is_store   <= mem_write;
        r_rdata      <= {XLEN{1'b0}};
`ifdef LSU_MISALIGN_CHECK_EN
        r_misalign   <= w_misalign;
`endif
      end else if (r_state == S_WAIT && dmem_rsp_valid) begin
        r_rdata <= r_is_store ? {XLEN{1'b0}} : w_ext;
      end
    end
  end

  // Outputs decode from state; request fields are zero outside REQ.
  always_comb begin
    lsu_stall      = (r_state == S_REQ) || (r_state == S_WAIT) || ((r_state == S_IDLE) && w_start);
    lsu_done       = (r_state == S_DONE);
    lsu_rdata      = {XLEN{1'b0}};
    dmem_req_valid = 1'b0;
    dmem_req_addr  = {XLEN{1'b0}};
    dmem_req_wen   = 1'b0;
    dmem_req_wmask = 8'h00;
    dmem_req_wdata = {XLEN{1'b0}};
    if (r_state == S_DONE) begin
      lsu_rdata = r_rdata;
    end else begin
      lsu_rdata = {XLEN{1'b0}};
    end
    if (r_state == S_REQ) begin
      dmem_req_valid = 1'b1;
      dmem_req_addr  = {r_addr[XLEN-1:3], 3'b000};
      dmem_req_wen   = r_is_store;
      dmem_req_wmask = r_is_store ? store_mask(r_store_type, r_addr[2:0]) : 8'h00;
      dmem_req_wdata = r_is_store ? (r_wdata << {r_addr[2:0], 3'b000}) : {XLEN{1'b0}};
    end else begin
      dmem_req_valid = 1'b0;
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign lsu_misalign = (r_state == S_DONE) && r_misalign;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a small handshaking memory model drives the
// bus while hand-computed results are compared through chk_eq.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, mem_read, mem_write;
  logic [2:0]  load_type, store_type;
  logic [63:0] addr, wdata;
  logic        lsu_stall, lsu_done;
  logic [63:0] lsu_rdata;
  logic        dmem_req_valid, dmem_req_ready;
  logic [63:0] dmem_req_addr;
  logic        dmem_req_wen;
  logic [7:0]  dmem_req_wmask;
  logic [63:0] dmem_req_wdata;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rsp_data;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        lsu_misalign;
`endif

  always #5 clk = ~clk;

  lsu_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write),
    .load_type(load_type), .store_type(store_type), .addr(addr), .wdata(wdata),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wen(dmem_req_wen),
    .dmem_req_wmask(dmem_req_wmask), .dmem_req_wdata(dmem_req_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data)
`ifdef LSU_MISALIGN_CHECK_EN
    , .lsu_misalign(lsu_misalign)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  int          obs_lat, obs_req_cycles, obs_stall_bad, obs_unstable;
  logic [63:0] obs_rdata, obs_addr, obs_wdata;
  logic [7:0]  obs_mask;
  logic        obs_wen, obs_done, obs_done_after, obs_reqv_after, obs_start_stall;
  logic        obs_misalign, obs_misalign_after;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
    end
  endtask

  // Issues one access at a negedge and plays the memory side until lsu_done.
  task automatic run_access(input logic mr, input logic mw, input logic [2:0] lt,
                            input logic [2:0] st, input logic [63:0] a, input logic [63:0] wd,
                            input logic [63:0] rd, input int ready_dly, input logic hold);
    logic hs;
    int   waited;
    hs = 1'b0; waited = 0;
    obs_lat = 1; obs_req_cycles = 0; obs_stall_bad = 0; obs_unstable = 0;
    obs_done = 1'b0; obs_rdata = 64'h0; obs_addr = 64'h0; obs_wdata = 64'h0;
    obs_mask = 8'h00; obs_wen = 1'b0; obs_misalign = 1'b0; obs_misalign_after = 1'b0;
    ex_valid = 1'b1; mem_read = mr; mem_write = mw; load_type = lt; store_type = st;
    addr = a; wdata = wd; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    #1 obs_start_stall = lsu_stall;
    @(negedge clk);
    if (!hold) begin
      ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      load_type = LT_NONE; store_type = ST_NONE;
      addr = 64'hFFFF_FFFF_FFFF_FFFF; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    end
    for (int c = 0; c < 30 && !obs_done; c++) begin
      obs_lat++;
      dmem_rsp_valid = hs;
      dmem_rsp_data  = hs ? rd : 64'hDEAD_BEEF_DEAD_BEEF;
      hs = 1'b0;
      if (lsu_done) begin
        obs_done  = 1'b1;
        obs_rdata = lsu_rdata;
        if (lsu_stall) obs_stall_bad++;
`ifdef LSU_MISALIGN_CHECK_EN
        obs_misalign = lsu_misalign;
`endif
        dmem_req_ready = 1'b0;
      end else begin
        if (!lsu_stall) obs_stall_bad++;
        if (dmem_req_valid) begin
          if (obs_req_cycles > 0 && (dmem_req_addr !== obs_addr || dmem_req_wdata !== obs_wdata ||
              dmem_req_wmask !== obs_mask || dmem_req_wen !== obs_wen)) obs_unstable++;
          obs_addr = dmem_req_addr; obs_wdata = dmem_req_wdata;
          obs_mask = dmem_req_wmask; obs_wen = dmem_req_wen;
          obs_req_cycles++;
          if (waited == ready_dly) begin
            dmem_req_ready = 1'b1; hs = 1'b1;
          end else begin
            dmem_req_ready = 1'b0; waited++;
          end
        end else begin
          dmem_req_ready = 1'b0;
        end
        @(negedge clk);
      end
    end
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    obs_done_after = lsu_done;
    obs_reqv_after = dmem_req_valid;
`ifdef LSU_MISALIGN_CHECK_EN
    obs_misalign_after = lsu_misalign;
`endif
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    load_type = LT_NONE; store_type = ST_NONE; addr = 64'h0; wdata = 64'h0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_data = 64'h0;
    repeat (2) @(negedge clk);
    chk_eq("rst_stall", lsu_stall, 64'd0);
    chk_eq("rst_done", lsu_done, 64'd0);
    chk_eq("rst_reqv", dmem_req_valid, 64'd0);
    chk_eq("rst_fields", {dmem_req_wen, dmem_req_wmask, dmem_req_addr | dmem_req_wdata | lsu_rdata}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // lb with sign extension, minimum latency
    run_access(1'b1, 1'b0, LT_LB, ST_NONE, 64'h0000_0040_0000_1003, 64'h0, 64'h0000_0000_8000_0000, 0, 1'b0);
    chk_eq("lb_done", obs_done, 64'd1);
    chk_eq("lb_lat", obs_lat, 64'd4);
    chk_eq("lb_rdata", obs_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    chk_eq("lb_addr", obs_addr, 64'h0000_0040_0000_1000);
    chk_eq("lb_wen", obs_wen, 64'd0);
    chk_eq("lb_start_stall", obs_start_stall, 64'd1);
    chk_eq("lb_stall", obs_stall_bad, 64'd0);
    chk_eq("lb_done_pulse", obs_done_after, 64'd0);

    // sh with ready held low for three cycles
    run_access(1'b0, 1'b1, LT_NONE, ST_SH, 64'h0000_0040_0000_2006, 64'h0000_0000_0000_ABCD,
               64'h0123_4567_89AB_CDEF, 3, 1'b0);
    chk_eq("sh_req_cycles", obs_req_cycles, 64'd4);
    chk_eq("sh_stable", obs_unstable, 64'd0);
    chk_eq("sh_mask", obs_mask, 64'hC0);
    chk_eq("sh_wdata", obs_wdata, 64'hABCD_0000_0000_0000);
    chk_eq("sh_addr", obs_addr, 64'h0000_0040_0000_2000);
    chk_eq("sh_wen", obs_wen, 64'd1);
    chk_eq("sh_lat", obs_lat, 64'd7);
    chk_eq("sh_rdata", obs_rdata, 64'd0);
    chk_eq("sh_stall", obs_stall_bad, 64'd0);

    run_access(1'b1, 1'b0, LT_LWU, ST_NONE, 64'h0000_0000_0000_3004, 64'h0, 64'hF000_0001_1234_5678, 1, 1'b0);
    chk_eq("lwu_rdata", obs_rdata, 64'h0000_0000_F000_0001);
    chk_eq("lwu_lat", obs_lat, 64'd5);
    run_access(1'b1, 1'b0, LT_LW, ST_NONE, 64'h0000_0000_0000_3000, 64'h0, 64'h1234_5678_8000_0001, 0, 1'b0);
    chk_eq("lw_rdata", obs_rdata, 64'hFFFF_FFFF_8000_0001);
    run_access(1'b1, 1'b0, LT_LHU, ST_NONE, 64'h0000_0000_0000_5002, 64'h0, 64'h0000_0000_BEEF_0000, 0, 1'b0);
    chk_eq("lhu_rdata", obs_rdata, 64'h0000_0000_0000_BEEF);
    run_access(1'b1, 1'b0, LT_LH, ST_NONE, 64'h0000_0000_0000_5006, 64'h0, 64'h8001_0000_0000_0000, 0, 1'b0);
    chk_eq("lh_rdata", obs_rdata, 64'hFFFF_FFFF_FFFF_8001);
    run_access(1'b1, 1'b0, LT_LBU, ST_NONE, 64'h0000_0000_0000_5007, 64'h0, 64'hA500_0000_0000_0000, 0, 1'b0);
    chk_eq("lbu_rdata", obs_rdata, 64'h0000_0000_0000_00A5);
    run_access(1'b0, 1'b1, LT_NONE, ST_SB, 64'h0000_0000_0000_7007, 64'h0000_0000_0000_005A, 64'h0, 0, 1'b0);
    chk_eq("sb_mask", obs_mask, 64'h80);
    chk_eq("sb_wdata", obs_wdata, 64'h5A00_0000_0000_0000);
    run_access(1'b0, 1'b1, LT_NONE, ST_SW, 64'h0000_0000_0000_7004, 64'hFFFF_FFFF_1234_5678, 64'h0, 0, 1'b0);
    chk_eq("sw_mask", obs_mask, 64'hF0);
    chk_eq("sw_wdata", obs_wdata, 64'h1234_5678_0000_0000);

`ifdef LSU_MISALIGN_CHECK_EN
    run_access(1'b1, 1'b0, LT_LD, ST_NONE, 64'h0000_0000_0000_8004, 64'h0, 64'h1111_2222_3333_4444, 0, 1'b0);
    chk_eq("mis_req_cycles", obs_req_cycles, 64'd0);
    chk_eq("mis_flag", obs_misalign, 64'd1);
    chk_eq("mis_done", obs_done, 64'd1);
    chk_eq("mis_rdata", obs_rdata, 64'd0);
    chk_eq("mis_lat", obs_lat, 64'd2);
    chk_eq("mis_pulse", obs_misalign_after, 64'd0);
`else
    run_access(1'b0, 1'b1, LT_NONE, ST_SW, 64'h0000_0000_0000_8006, 64'h0000_0000_CAFE_F00D, 64'h0, 0, 1'b0);
    chk_eq("sw_trunc_mask", obs_mask, 64'hC0);
    chk_eq("sw_trunc_wdata", obs_wdata, 64'hF00D_0000_0000_0000);
    run_access(1'b1, 1'b0, LT_LD, ST_NONE, 64'h0000_0000_0000_8004, 64'h0, 64'h1111_2222_3333_4444, 0, 1'b0);
    chk_eq("ld_off4_rdata", obs_rdata, 64'h0000_0000_1111_2222);
    chk_eq("ld_off4_reqs", obs_req_cycles, 64'd1);
`endif

    // back-to-back: sd held on the pipeline inputs, ld issued right after DONE
    run_access(1'b0, 1'b1, LT_NONE, ST_SD, 64'h0000_0000_0000_6000, 64'h1122_3344_5566_7788, 64'h0, 0, 1'b1);
    chk_eq("sd_mask", obs_mask, 64'hFF);
    chk_eq("sd_wdata", obs_wdata, 64'h1122_3344_5566_7788);
    chk_eq("sd_lat", obs_lat, 64'd4);
    chk_eq("sd_req_cycles", obs_req_cycles, 64'd1);
    chk_eq("sd_no_accept_in_done", obs_reqv_after, 64'd0);
    chk_eq("sd_stall", obs_stall_bad, 64'd0);
    run_access(1'b1, 1'b0, LT_LD, ST_NONE, 64'h0000_0000_0000_6008, 64'h0, 64'h8877_6655_4433_2211, 0, 1'b0);
    chk_eq("ld_b2b_lat", obs_lat, 64'd4);
    chk_eq("ld_b2b_rdata", obs_rdata, 64'h8877_6655_4433_2211);
    chk_eq("ld_b2b_start_stall", obs_start_stall, 64'd1);
    chk_eq("ld_b2b_stall", obs_stall_bad, 64'd0);

    // reset while waiting for the response, then a stale response arrives
    ex_valid = 1'b1; mem_read = 1'b1; load_type = LT_LD; addr = 64'h0000_0000_0000_4000;
    @(negedge clk);
    ex_valid = 1'b0; mem_read = 1'b0; dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    chk_eq("wait_stall", lsu_stall, 64'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("rst_wait_reqv", dmem_req_valid, 64'd0);
    chk_eq("rst_wait_stall", lsu_stall, 64'd0);
    chk_eq("rst_wait_done", lsu_done, 64'd0);
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 64'h1111_1111_1111_1111;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_eq("rst_stale_rsp", {61'd0, lsu_stall, dmem_req_valid, lsu_done}, 64'd0);
      if (i == 1) dmem_rsp_valid = 1'b0;
    end
    chk_eq("rst_stale_rdata", lsu_rdata, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
